sram_banked_mp: RTL



---
 rtl/sram_banked_pkg.sv | 27 ++
 rtl/sram_bank_arb.sv | 56 +++++
 rtl/sram_wrapper.sv | 44 ++++
 rtl/sram_banked_mp.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sram_banked_pkg.sv
// Shared parameter helpers for the banked multi-port SRAM.
package sram_banked_pkg;

    localparam int MAX_PORTS = 4;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bank_bits(input int n_banks);
        return $clog2(n_banks);
    endfunction

    // Legal geometry: byte-multiple width, power-of-2 banks, supported macro depths
    function automatic bit params_ok(input int width, input int depth,
                                     input int n_banks, input int n_ports);
        int per;
        int rem;
        per = (n_banks > 0) ? (depth / n_banks) : 0;
        rem = (n_banks > 0) ? (depth % n_banks) : 1;
        return (width > 0) && ((width % 8) == 0) &&
               (n_banks >= 1) && ((n_banks & (n_banks - 1)) == 0) &&
               (n_ports >= 1) && (n_ports <= MAX_PORTS) && (rem == 0) &&
               ((per == 128) || (per == 256) || ((per > 0) && ((per % 512) == 0)));
    endfunction

endpackage

// File: rtl/sram_bank_arb.sv
// Per-bank arbiter producing a one-hot grant. Define SRAM_BANKED_FIXED_PRIO_EN
// for fixed priority (lowest port index wins); otherwise round-robin.
module sram_bank_arb #(
    parameter int N_PORTS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] hit,
    output logic [N_PORTS-1:0] gnt
);
`ifdef SRAM_BANKED_FIXED_PRIO_EN
    logic unused_s;
    assign unused_s = clk ^ rst_n;

    // Isolate the lowest set request bit
    always_comb begin
        gnt = hit & (~hit + N_PORTS'(1));
    end
`else
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic             found_s;

    // Rotating search starting at ptr_r; winner+1 becomes the next pointer
    always_comb begin
        gnt       = '0;
        ptr_nxt_s = ptr_r;
        found_s   = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (!found_s && hit[j] && (j == ((int'(ptr_r) + i) % N_PORTS))) begin
                    gnt[j]    = 1'b1;
                    ptr_nxt_s = PTR_W'((j + 1) % N_PORTS);
                    found_s   = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

endmodule

// File: rtl/sram_wrapper.sv
// Behavioural stand-in for the single-ported SRAM macro wrapper (active-low CEN,
// active-low write and byte enables, registered read data).
module sram_wrapper #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    inout  wire                      VDD,
    inout  wire                      VSS,
    input  logic                     chicken_cen_force,
    input  logic                     cs_n,
    input  logic                     we_n,
    input  logic [WIDTH/8-1:0]       be_n,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;
    logic             cen_s;
    logic             unused_s;

    assign cen_s    = cs_n & ~chicken_cen_force;
    assign unused_s = VDD ^ VSS;
    assign rdata    = rdata_r;

    // Array access: byte-masked write or registered read
    always_ff @(posedge clk) begin
        if (!cen_s) begin
            if (!we_n) begin
                for (int i = 0; i < WIDTH / 8; i++) begin
                    if (!be_n[i]) begin
                        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[addr];
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: rtl/sram_banked_mp.sv
// Multi-port, word-interleaved multi-bank SRAM with per-bank arbitration.
// Optional macro SRAM_BANKED_FIXED_PRIO_EN selects fixed-priority arbitration.
module sram_banked_mp
    import sram_banked_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2048,
    parameter int N_BANKS = 4,
    parameter int N_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    inout  wire                                 VDD,
    inout  wire                                 VSS,
    input  logic                                chicken_cen_force,
    input  logic [N_PORTS-1:0]                  req,
    input  logic [N_PORTS-1:0]                  we_n,
    input  logic [N_PORTS*WIDTH/8-1:0]          be_n,
    input  logic [N_PORTS*addr_bits(DEPTH)-1:0] addr,
    input  logic [N_PORTS*WIDTH-1:0]            wdata,
    output logic [N_PORTS-1:0]                  gnt,
    output logic [N_PORTS-1:0]                  rvalid,
    output logic [N_PORTS*WIDTH-1:0]            rdata
);
    localparam int NB  = WIDTH / 8;
    localparam int AW  = addr_bits(DEPTH);
    localparam int BB  = bank_bits(N_BANKS);
    localparam int BSW = (BB > 0) ? BB : 1;
    localparam int BAW = AW - BB;

    if (!params_ok(WIDTH, DEPTH, N_BANKS, N_PORTS)) begin : g_param_chk
        $fatal(1, "sram_banked_mp: illegal parameter combination");
    end

    logic [BSW-1:0]     psel_s [N_PORTS];
    logic [BAW-1:0]     paddr_s [N_PORTS];
    logic [N_PORTS-1:0] hit_s [N_BANKS];
    logic [N_PORTS-1:0] bgnt_s [N_BANKS];
    logic [N_BANKS-1:0] bank_cs_n_s;
    logic [N_BANKS-1:0] bank_we_n_s;
    logic [NB-1:0]      bank_be_n_s [N_BANKS];
    logic [BAW-1:0]     bank_addr_s [N_BANKS];
    logic [WIDTH-1:0]   bank_wdata_s [N_BANKS];
    logic [WIDTH-1:0]   bank_rdata_s [N_BANKS];
    logic [BSW-1:0]     dph_r [N_PORTS];
    logic [N_PORTS-1:0] rvalid_r;

    // Bank decode; reset masks every request so no bank is selected
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            psel_s[p]  = BSW'(addr[p*AW +: AW] & AW'(N_BANKS - 1));
            paddr_s[p] = BAW'(addr[p*AW +: AW] >> BB);
        end
        for (int b = 0; b < N_BANKS; b++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                hit_s[b][p] = rst_n && req[p] && (psel_s[p] == BSW'(b));
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        sram_bank_arb #(.N_PORTS(N_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .hit   (hit_s[b]),
            .gnt   (bgnt_s[b])
        );

        sram_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH / N_BANKS)) u_sram (
            .clk               (clk),
            .VDD               (VDD),
            .VSS               (VSS),
            .chicken_cen_force (chicken_cen_force),
            .cs_n              (bank_cs_n_s[b]),
            .we_n              (bank_we_n_s[b]),
            .be_n              (bank_be_n_s[b]),
            .addr              (bank_addr_s[b]),
            .wdata             (bank_wdata_s[b]),
            .rdata             (bank_rdata_s[b])
        );
    end

    // Steer the granted port onto each bank; idle banks see a deselected read
    always_comb begin
        gnt = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            gnt             = gnt | bgnt_s[b];
            bank_cs_n_s[b]  = ~|bgnt_s[b];
            bank_we_n_s[b]  = 1'b1;
            bank_be_n_s[b]  = '1;
            bank_addr_s[b]  = '0;
            bank_wdata_s[b] = '0;
            for (int p = 0; p < N_PORTS; p++) begin
                if (bgnt_s[b][p]) begin
                    bank_we_n_s[b]  = we_n[p];
                    bank_be_n_s[b]  = be_n[p*NB +: NB];
                    bank_addr_s[b]  = paddr_s[p];
                    bank_wdata_s[b] = wdata[p*WIDTH +: WIDTH];
                end else begin
                    bank_we_n_s[b] = bank_we_n_s[b];
                end
            end
        end
    end

    // Per-port read-return tracking: valid flag and bank index of the data phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_r <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                dph_r[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                rvalid_r[p] <= gnt[p] & we_n[p];
                if (gnt[p]) begin
                    dph_r[p] <= psel_s[p];
                end else begin
                    dph_r[p] <= dph_r[p];
                end
            end
        end
    end

    // A read landing while reset is asserted is suppressed immediately
    assign rvalid = rvalid_r & {N_PORTS{rst_n}};

    // Return-data mux; zero whenever the port has no valid data
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (rvalid[p]) begin
                rdata[p*WIDTH +: WIDTH] = bank_rdata_s[dph_r[p]];
            end else begin
                rdata[p*WIDTH +: WIDTH] = '0;
            end
        end
    end

endmodule
